// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: detects per-channel rising/falling edges, queues one event per
// channel and presents them round-robin through a single valid/ready output slot.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_sig,
    input  logic            cfg_we,
    input  logic [ID_W-1:0] cfg_ch,
    input  logic [1:0]      cfg_mode,
    input  logic            ovf_clr,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [N_CH-1:0] overflow
);

    logic [N_CH-1:0]      prev_p0;
    logic [N_CH-1:0][1:0] mode;
    logic [N_CH-1:0]      pending_p1;
    logic [N_CH-1:0]      dir_p1;
    logic [ID_W-1:0]      last_grant;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] detect;
    logic [N_CH-1:0] grant_1h;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] ovf_set;
    logic [N_CH-1:0] clr_1h;
    logic [N_CH-1:0] pending_nxt;
    logic [N_CH-1:0] dir_nxt;
    logic [ID_W:0]   pick;
    logic            slot_free;
    logic            grant_vld;
    logic [ID_W-1:0] grant_ch;

    // Returns {found, index}; scanning downward lets the channel nearest last+1 win.
    function automatic logic [ID_W:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [ID_W-1:0] last);
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        logic [ID_W:0]   result;
        result = '0;
        for (int i = N_CH; i >= 1; i--) begin
            sum = {1'b0, last} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_CH)) begin
                sum = sum - (ID_W+1)'(N_CH);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    always_comb begin
        rise = in_sig & ~prev_p0;
        fall = ~in_sig & prev_p0;
        for (int k = 0; k < N_CH; k++) begin
            detect[k] = (rise[k] & mode[k][0]) | (fall[k] & mode[k][1]);
        end

        slot_free = ~evt_valid | evt_ready;
        pick      = rr_pick(pending_p1, last_grant);
        grant_vld = slot_free & pick[ID_W];
        grant_ch  = pick[ID_W-1:0];

        grant_1h = '0;
        if (grant_vld) begin
            grant_1h[grant_ch] = 1'b1;
        end

        // A channel being granted this cycle frees its pending slot for a new edge.
        held    = pending_p1 & ~grant_1h;
        ovf_set = detect & held;
        accept  = detect & ~held;

        clr_1h = '0;
        if (cfg_we && (cfg_mode == 2'b00)) begin
            clr_1h[cfg_ch] = 1'b1;
        end

        pending_nxt = (held | accept) & ~clr_1h;
        dir_nxt     = (dir_p1 & ~accept) | (rise & accept);
    end

    // Stage p0: edge history; stage p1: pending events; output slot follows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_p0    <= '0;
            mode       <= '0;
            pending_p1 <= '0;
            dir_p1     <= '0;
            overflow   <= '0;
            last_grant <= ID_W'(N_CH - 1);
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            evt_rise   <= 1'b0;
        end else begin
            prev_p0    <= in_sig;
            pending_p1 <= pending_nxt;
            dir_p1     <= dir_nxt;
            overflow   <= (ovf_clr ? '0 : overflow) | ovf_set;
            if (cfg_we) begin
                mode[cfg_ch] <= cfg_mode;
            end
            if (slot_free) begin
                evt_valid <= grant_vld;
            end
            if (grant_vld) begin
                evt_ch     <= grant_ch;
                evt_rise   <= dir_p1[grant_ch];
                last_grant <= grant_ch;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a per-channel event model pushes expected
// events into a queue; a monitor compares the output slot and overflow flags each cycle.
module tb_edge_event_arbiter;
    localparam int N_CH = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] in_sig;
    logic            cfg_we;
    logic [ID_W-1:0] cfg_ch;
    logic [1:0]      cfg_mode;
    logic            ovf_clr;
    logic            evt_ready;
    logic            evt_valid;
    logic [ID_W-1:0] evt_ch;
    logic            evt_rise;
    logic [N_CH-1:0] overflow;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_sig   (in_sig),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .ovf_clr  (ovf_clr),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_ch   (evt_ch),
        .evt_rise (evt_rise),
        .overflow (overflow)
    );

    // Reference model: one queued event per channel, one presented event at a time.
    logic [N_CH-1:0] prev_m;
    logic [N_CH-1:0] pend_m;
    logic [N_CH-1:0] dir_m;
    logic [N_CH-1:0] ovf_m;
    logic [1:0]      mode_m [N_CH];
    int              last_m;
    int              exp_q [$];
    int              n_checks = 0;
    int              n_errs = 0;

    task automatic model_reset();
        prev_m = '0;
        pend_m = '0;
        dir_m  = '0;
        ovf_m  = '0;
        for (int k = 0; k < N_CH; k++) mode_m[k] = 2'b00;
        last_m = N_CH - 1;
        exp_q.delete();
    endtask

    // Called at the active edge with the inputs that edge samples.
    task automatic model_step();
        int  g;
        int  k;
        bit  r;
        bit  f;
        bit  det;
        if (!rst) begin
            model_reset();
            return;
        end
        g = -1;
        if (exp_q.size() == 0) begin
            for (int i = 1; i <= N_CH; i++) begin
                k = (last_m + i) % N_CH;
                if (g < 0 && pend_m[k]) g = k;
            end
        end
        if (g >= 0) begin
            exp_q.push_back(g * 2 + (dir_m[g] ? 1 : 0));
            pend_m[g] = 1'b0;
            last_m = g;
        end
        if (ovf_clr) ovf_m = '0;
        for (int c = 0; c < N_CH; c++) begin
            r   = in_sig[c] && !prev_m[c];
            f   = !in_sig[c] && prev_m[c];
            det = (r && mode_m[c][0]) || (f && mode_m[c][1]);
            if (det) begin
                if (pend_m[c]) begin
                    ovf_m[c] = 1'b1;
                end else begin
                    pend_m[c] = 1'b1;
                    dir_m[c]  = r;
                end
            end
        end
        if (cfg_we) begin
            mode_m[cfg_ch] = cfg_mode;
            if (cfg_mode == 2'b00) pend_m[cfg_ch] = 1'b0;
        end
        prev_m = in_sig;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cfg_we  = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cfg(input int ch, input logic [1:0] m);
        cfg_we   = 1'b1;
        cfg_ch   = ID_W'(ch);
        cfg_mode = m;
        step();
    endtask

    task automatic assert_rst();
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor
    initial begin
        int              e;
        logic [ID_W-1:0] ec;
        logic            er;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q[0];
                ec = ID_W'(e >> 1);
                er = e[0];
                n_checks++;
                if (!(evt_valid === 1'b1 && evt_ch === ec && evt_rise === er)) begin
                    n_errs++;
                    $display("FAIL event @%0t: got valid=%0b ch=%0d rise=%0b, want valid=1 ch=%0d rise=%0b",
                             $time, evt_valid, evt_ch, evt_rise, ec, er);
                end
                if (evt_ready) void'(exp_q.pop_front());
            end else begin
                n_checks++;
                if (evt_valid !== 1'b0) begin
                    n_errs++;
                    $display("FAIL idle @%0t: got valid=%0b ch=%0d, want valid=0",
                             $time, evt_valid, evt_ch);
                end
                if (!rst) begin
                    n_checks++;
                    if (evt_ch !== '0 || evt_rise !== 1'b0) begin
                        n_errs++;
                        $display("FAIL reset_out @%0t: got ch=%0d rise=%0b, want ch=0 rise=0",
                                 $time, evt_ch, evt_rise);
                    end
                end
            end
            n_checks++;
            if (overflow !== ovf_m) begin
                n_errs++;
                $display("FAIL overflow @%0t: got %b, want %b", $time, overflow, ovf_m);
            end
        end
    end

    // Stimulus
    initial begin
        rst       = 1'b0;
        in_sig    = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = 2'b00;
        ovf_clr   = 1'b0;
        evt_ready = 1'b1;
        model_reset();
        idle(2);

        // Line high at reset release with all modes disabled
        in_sig = 4'hF; idle(1);
        rst = 1'b1;    idle(4);
        in_sig = '0;   idle(2);

        // Single rising edge on channel 2, later fall ignored
        cfg(2, 2'b01);
        in_sig = 4'b0100; idle(4);
        in_sig = '0;      idle(4);

        // All channels both-edge, simultaneous rise from reset state
        assert_rst(); idle(1); rst = 1'b1;
        for (int k = 0; k < N_CH; k++) cfg(k, 2'b11);
        in_sig = 4'hF; idle(6);
        in_sig = '0;   idle(6);

        // Overflow on channel 1 under backpressure, then clear
        assert_rst(); idle(1); rst = 1'b1;
        cfg(1, 2'b11);
        evt_ready = 1'b0;
        in_sig = 4'b0010; step();
        in_sig = 4'b0000; step();
        in_sig = 4'b0010; step();
        idle(2);
        ovf_clr = 1'b1; step();
        idle(1);
        evt_ready = 1'b1; idle(4);

        // Long backpressure with several channels pending
        cfg(0, 2'b11); cfg(2, 2'b11); cfg(3, 2'b11);
        evt_ready = 1'b0;
        in_sig = 4'hF; idle(7);
        evt_ready = 1'b1; idle(8);

        // Disable channel 3 while its event is pending
        evt_ready = 1'b0;
        in_sig = '0; step();
        idle(2);
        cfg(3, 2'b00);
        idle(2);
        evt_ready = 1'b1; idle(8);

        // Reset mid-transfer with events pending
        cfg(3, 2'b11);
        evt_ready = 1'b0;
        in_sig = 4'hF; idle(3);
        assert_rst(); idle(2);
        rst = 1'b1;
        evt_ready = 1'b1; idle(5);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                assert_rst();
            end
            for (int b = 0; b < N_CH; b++) begin
                if ($urandom_range(0, 3) == 0) in_sig[b] = ~in_sig[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = ID_W'($urandom_range(0, N_CH - 1));
                cfg_mode = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 24) == 0) ovf_clr = 1'b1;
            step();
        end

        rst = 1'b1;
        evt_ready = 1'b1;
        idle(12);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
